// File: rtl/temporizador_ctrl_pkg.sv
// Shared definitions for the countdown timer controller: FSM state encodings
// (also used by the bench to decode the state output) and the default width.
package temporizador_ctrl_pkg;

   localparam int WIDTH_DEF = 6;

   // Encodings are visible on the state output, so they are fixed values.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/temporizador_ctrl_contador_desc_carga.sv
// contador_desc_carga: WIDTH-bit synchronous down counter.
// Priority: clear > load > enabled decrement. Decrement saturates at zero.
module contador_desc_carga #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_reg;

   // Counter register: clear, then load, then decrement (never wraps below 0).
   always_ff @(posedge clk) begin
      if (clr) begin
         q_reg <= '0;
      end else if (load) begin
         q_reg <= d;
      end else if (en && (q_reg != '0)) begin
         q_reg <= q_reg - WIDTH'(1);
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/temporizador_ctrl.sv
// temporizador_ctrl: start/pause/abort countdown timer built around a loadable
// down counter. FSM + saved reload value + registered busy/done outputs.
// Optional feature macro AUTO_RELOAD_EN: when defined, reaching the end of a
// count reloads the saved value, stays in RUN and pulses done (periodic mode).
module temporizador_ctrl
   import temporizador_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state
);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] saved_reg, saved_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;
   logic             done_pulse;
   logic             cnt_load;
   logic             cnt_en;
   logic [WIDTH-1:0] cnt_d;
   logic             last_step;

   contador_desc_carga #(
      .WIDTH (WIDTH)
   ) u_contador (
      .clk  (clk),
      .clr  (clr),
      .load (cnt_load),
      .en   (cnt_en),
      .d    (cnt_d),
      .q    (count)
   );

   // The step that ends a count; zero is included so a stray zero in RUN
   // cannot leave the FSM stuck.
   assign last_step = (count == WIDTH'(1)) || (count == '0);

   // Next-state, counter control and output decode.
   always_comb begin
      state_next = state_reg;
      saved_next = saved_reg;
      cnt_load   = 1'b0;
      cnt_en     = 1'b0;
      cnt_d      = load_val;
      done_pulse = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               if (load_val != '0) begin
                  cnt_load   = 1'b1;
                  cnt_d      = load_val;
                  saved_next = load_val;
                  state_next = ST_RUN;
               end else begin
                  // Zero-length delay completes immediately without running.
                  done_pulse = 1'b1;
               end
            end
         end

         ST_RUN: begin
            if (abort) begin
               cnt_load   = 1'b1;
               cnt_d      = '0;
               state_next = ST_IDLE;
            end else if (pause) begin
               state_next = ST_PAUSE;
            end else if (last_step) begin
`ifdef AUTO_RELOAD_EN
               cnt_load   = 1'b1;
               cnt_d      = saved_reg;
               done_pulse = 1'b1;
`else
               cnt_en     = 1'b1;
               state_next = ST_DONE;
`endif
            end else begin
               cnt_en = 1'b1;
            end
         end

         ST_PAUSE: begin
            if (abort) begin
               cnt_load   = 1'b1;
               cnt_d      = '0;
               state_next = ST_IDLE;
            end else if (!pause) begin
               // Re-entering RUN costs this edge; decrement resumes next edge.
               state_next = ST_RUN;
            end
         end

         ST_DONE: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      busy_next = (state_next == ST_RUN) || (state_next == ST_PAUSE);
      done_next = (state_next == ST_DONE) || done_pulse;
   end

   // State, saved reload value and registered outputs; clr wins over all.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_reg <= ST_IDLE;
         saved_reg <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         saved_reg <= saved_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   assign busy  = busy_reg;
   assign done  = done_reg;
   assign state = state_reg;

endmodule

// File: tb/tb_temporizador_ctrl.sv
// Bench for temporizador_ctrl: a per-cycle vector table plus hand-written
// pause and mid-run clear sequences. Follows AUTO_RELOAD_EN if defined.
module tb_temporizador_ctrl;
   import temporizador_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       abort = 1'b0;
   logic [5:0] load_val = '0;
   logic [5:0] count;
   logic       busy;
   logic       done;
   logic [1:0] state;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic       c;
      logic       s;
      logic       p;
      logic       a;
      logic [5:0] lv;
      logic [5:0] e_count;
      logic [1:0] e_state;
      logic       e_busy;
      logic       e_done;
   } vec_t;

   vec_t vecs[$];

   temporizador_ctrl #(.WIDTH(6)) dut (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .pause    (pause),
      .abort    (abort),
      .load_val (load_val),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .state    (state)
   );

   always #10 clk = ~clk;

   task automatic add(input logic c, input logic s, input logic p, input logic a,
                      input logic [5:0] lv, input logic [5:0] ec,
                      input logic [1:0] es, input logic eb, input logic ed);
      vec_t v;
      v.c = c; v.s = s; v.p = p; v.a = a; v.lv = lv;
      v.e_count = ec; v.e_state = es; v.e_busy = eb; v.e_done = ed;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic c, input logic s, input logic p, input logic a,
                        input logic [5:0] lv);
      clr = c; start = s; pause = p; abort = a; load_val = lv;
   endtask

   // Apply inputs, let one rising edge pass, then sample 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [5:0] ec, input logic [1:0] es,
                          input logic eb, input logic ed);
      chk({tag, "_count"}, int'(count), int'(ec));
      chk({tag, "_state"}, int'(state), int'(es));
      chk({tag, "_busy"},  int'(busy),  int'(eb));
      chk({tag, "_done"},  int'(done),  int'(ed));
      $display("%s: count=%0d state=%0d busy=%0d done=%0d", tag, count, state, busy, done);
   endtask

   initial begin
      // ---------------- vector table ----------------
      // Reset held 2 cycles with start asserted.
      add(1, 1, 0, 0, 6'd5, 6'd0, ST_IDLE, 0, 0);
      add(1, 1, 0, 0, 6'd5, 6'd0, ST_IDLE, 0, 0);
`ifndef AUTO_RELOAD_EN
      // load 5: 5,4,3,2,1,0 then one DONE cycle.
      add(0, 1, 0, 0, 6'd5, 6'd5, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd4, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd3, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd2, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd1, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd0, ST_DONE, 0, 1);
      add(0, 0, 0, 0, 6'd0, 6'd0, ST_IDLE, 0, 0);
      // pause/abort ignored in IDLE.
      add(0, 0, 1, 1, 6'd7, 6'd0, ST_IDLE, 0, 0);
      // load 0: immediate done pulse, no RUN.
      add(0, 1, 0, 0, 6'd0, 6'd0, ST_IDLE, 0, 1);
      add(0, 0, 0, 0, 6'd0, 6'd0, ST_IDLE, 0, 0);
      // load 2; start in RUN and in DONE ignored.
      add(0, 1, 0, 0, 6'd2, 6'd2, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd1, ST_RUN, 1, 0);
      add(0, 1, 0, 0, 6'd9, 6'd0, ST_DONE, 0, 1);
      add(0, 1, 1, 1, 6'd9, 6'd0, ST_IDLE, 0, 0);
      // load 1: shortest run.
      add(0, 1, 0, 0, 6'd1, 6'd1, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd0, ST_DONE, 0, 1);
      add(0, 0, 0, 0, 6'd0, 6'd0, ST_IDLE, 0, 0);
      // load 8, abort when count=3.
      add(0, 1, 0, 0, 6'd8, 6'd8, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd7, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd6, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd5, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd4, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd3, ST_RUN, 1, 0);
      add(0, 0, 0, 1, 6'd0, 6'd0, ST_IDLE, 0, 0);
      add(0, 0, 0, 0, 6'd0, 6'd0, ST_IDLE, 0, 0);
`else
      // Auto-reload, load 3: 3,2,1,3(done),2,1,3(done), abort.
      add(0, 1, 0, 0, 6'd3, 6'd3, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd2, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd1, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd3, ST_RUN, 1, 1);
      add(0, 0, 0, 0, 6'd0, 6'd2, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd1, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd3, ST_RUN, 1, 1);
      add(0, 0, 0, 1, 6'd0, 6'd0, ST_IDLE, 0, 0);
      add(0, 0, 0, 0, 6'd0, 6'd0, ST_IDLE, 0, 0);
      // load 0 still gives a single done pulse from IDLE.
      add(0, 1, 0, 0, 6'd0, 6'd0, ST_IDLE, 0, 1);
      add(0, 0, 0, 0, 6'd0, 6'd0, ST_IDLE, 0, 0);
      // load 1: reloads every edge, done every edge.
      add(0, 1, 0, 0, 6'd1, 6'd1, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd1, ST_RUN, 1, 1);
      add(0, 0, 0, 0, 6'd0, 6'd1, ST_RUN, 1, 1);
      add(0, 0, 0, 1, 6'd0, 6'd0, ST_IDLE, 0, 0);
`endif
      // Abort from PAUSE; start ignored while paused.
      add(0, 1, 0, 0, 6'd4, 6'd4, ST_RUN, 1, 0);
      add(0, 0, 1, 0, 6'd0, 6'd4, ST_PAUSE, 1, 0);
      add(0, 1, 1, 0, 6'd9, 6'd4, ST_PAUSE, 1, 0);
      add(0, 0, 1, 1, 6'd0, 6'd0, ST_IDLE, 0, 0);
      // Maximum load value, then abort.
      add(0, 1, 0, 0, 6'd63, 6'd63, ST_RUN, 1, 0);
      add(0, 0, 0, 0, 6'd0, 6'd62, ST_RUN, 1, 0);
      add(0, 0, 0, 1, 6'd0, 6'd0, ST_IDLE, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].c, vecs[i].s, vecs[i].p, vecs[i].a, vecs[i].lv);
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_state,
                 vecs[i].e_busy, vecs[i].e_done);
      end

      // ---------------- pause sequence: load 10, pause 3 cycles at 7 ----------------
      drive(0, 1, 0, 0, 6'd10);
      tick();
      chk_all("pz_load", 6'd10, ST_RUN, 1, 0);
      drive(0, 0, 0, 0, 6'd0);
      for (int k = 9; k >= 7; k--) begin
         tick();
         chk_all($sformatf("pz_dec%0d", k), 6'(k), ST_RUN, 1, 0);
      end
      drive(0, 0, 1, 0, 6'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_all($sformatf("pz_hold%0d", k), 6'd7, ST_PAUSE, 1, 0);
      end
      drive(0, 0, 0, 0, 6'd0);
      tick();
      chk_all("pz_resume", 6'd7, ST_RUN, 1, 0);
      for (int k = 6; k >= 1; k--) begin
         tick();
         chk_all($sformatf("pz_run%0d", k), 6'(k), ST_RUN, 1, 0);
      end
      tick();
`ifndef AUTO_RELOAD_EN
      chk_all("pz_end", 6'd0, ST_DONE, 0, 1);
      tick();
      chk_all("pz_idle", 6'd0, ST_IDLE, 0, 0);
`else
      chk_all("pz_end", 6'd10, ST_RUN, 1, 1);
      drive(0, 0, 0, 1, 6'd0);
      tick();
      chk_all("pz_idle", 6'd0, ST_IDLE, 0, 0);
`endif

      // ---------------- clr mid-countdown at count=4 ----------------
      drive(0, 1, 0, 0, 6'd8);
      tick();
      chk_all("cl_load", 6'd8, ST_RUN, 1, 0);
      drive(0, 0, 0, 0, 6'd0);
      for (int k = 7; k >= 4; k--) begin
         tick();
         chk_all($sformatf("cl_dec%0d", k), 6'(k), ST_RUN, 1, 0);
      end
      drive(1, 0, 0, 0, 6'd0);
      tick();
      chk_all("cl_reset", 6'd0, ST_IDLE, 0, 0);
      drive(0, 0, 0, 0, 6'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_all($sformatf("cl_after%0d", k), 6'd0, ST_IDLE, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
